// File: rtl/mm_port_arbiter.sv
// ---------------------------------------------------------------------------
// mm_port_arbiter
//   Shares memory port B between the host loader/reader and the multiplier
//   engine. One access per cycle is granted. The grant is round-robin, and the
//   engine can hold the port for a bounded burst. Port-B read data is returned
//   to the requester that issued the read.
//
// Ports
//   clk, reset                  rising-edge clock, synchronous active-low reset
//   h_req/h_we/h_addr/h_wdata   host request fields
//   h_gnt/h_rvalid/h_rdata      host grant and read return
//   e_req/e_we/e_addr/e_wdata   engine request fields
//   e_lock                      engine requests burst ownership
//   e_gnt/e_rvalid/e_rdata      engine grant and read return
//   mem_addr/mem_data/mem_we    port-B request (held when idle, never X)
//   mem_q                       port-B read data, one-cycle latency
// ---------------------------------------------------------------------------
module mm_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int LOCK_MAX   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  h_req,
    input  logic                  h_we,
    input  logic [ADDR_WIDTH-1:0] h_addr,
    input  logic [DATA_WIDTH-1:0] h_wdata,
    output logic                  h_gnt,
    output logic                  h_rvalid,
    output logic [DATA_WIDTH-1:0] h_rdata,
    input  logic                  e_req,
    input  logic                  e_we,
    input  logic [ADDR_WIDTH-1:0] e_addr,
    input  logic [DATA_WIDTH-1:0] e_wdata,
    input  logic                  e_lock,
    output logic                  e_gnt,
    output logic                  e_rvalid,
    output logic [DATA_WIDTH-1:0] e_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

    // The state records which requester owned the port in a given cycle.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOST,
        ST_ENGINE,
        ST_ENGINE_LOCK
    } state_e;

    state_e                state_q,     state_d;
    logic                  last_eng_q,  last_eng_d;   // 1: engine owned the last granted access
    logic [CNT_W-1:0]      lock_cnt_q,  lock_cnt_d;
    logic                  rd_pend_q,   rd_pend_d;
    logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
    logic [DATA_WIDTH-1:0] data_hold_q, data_hold_d;
    logic                  lock_grant;

    // Grant decision. A locked engine wins until the count reaches LOCK_MAX.
    // After that, the normal round-robin rule applies. The engine was the last
    // owner, so a waiting host is served next.
    always_comb begin
        // NOTE: every signal gets a default before any branch; otherwise a path that skips the assignment would infer a latch.
        h_gnt      = 1'b0;
        e_gnt      = 1'b0;
        lock_grant = 1'b0;
        if (reset) begin
            if (e_lock && e_req && (lock_cnt_q < LOCK_MAX_C)) begin
                e_gnt      = 1'b1;
                lock_grant = 1'b1;
            end else if (h_req && e_req) begin
                if (last_eng_q) h_gnt = 1'b1;
                else            e_gnt = 1'b1;
            end else if (h_req) begin
                h_gnt = 1'b1;
            end else if (e_req) begin
                e_gnt = 1'b1;
            end
        end
    end

    // Port-B drive. When no access is granted, the last address and data are
    // replayed from the hold registers, so the bus never floats.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = addr_hold_q;
        mem_data = data_hold_q;
        if (h_gnt) begin
            mem_we   = h_we;
            mem_addr = h_addr;
            mem_data = h_wdata;
        end else if (e_gnt) begin
            mem_we   = e_we;
            mem_addr = e_addr;
            mem_data = e_wdata;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = ST_IDLE;
        last_eng_d  = last_eng_q;
        lock_cnt_d  = lock_cnt_q;
        rd_pend_d   = (h_gnt && !h_we) || (e_gnt && !e_we);
        addr_hold_d = mem_addr;
        data_hold_d = mem_data;

        if (h_gnt) begin
            state_d    = ST_HOST;
            last_eng_d = 1'b0;
        end else if (e_gnt) begin
            state_d    = e_lock ? ST_ENGINE_LOCK : ST_ENGINE;
            last_eng_d = 1'b1;
        end

        // Serving the host ends a burst. Dropping the lock also ends a burst.
        // The count saturates because lock_grant stops at LOCK_MAX.
        if (!e_lock || h_gnt) lock_cnt_d = '0;
        else if (lock_grant)  lock_cnt_d = lock_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is sampled at the clock edge only; every state register is cleared in this one branch.
        if (!reset) begin
            state_q     <= ST_IDLE;
            last_eng_q  <= 1'b0;
            lock_cnt_q  <= '0;
            rd_pend_q   <= 1'b0;
            addr_hold_q <= '0;
            data_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            last_eng_q  <= last_eng_d;
            lock_cnt_q  <= lock_cnt_d;
            rd_pend_q   <= rd_pend_d;
            addr_hold_q <= addr_hold_d;
            data_hold_q <= data_hold_d;
        end
    end

    // Read return. The previous cycle's owner is the owner of the pending
    // read. Returns are suppressed while reset is low, so a read that is in
    // flight when reset arrives is dropped.
    assign h_rvalid = reset && rd_pend_q && (state_q == ST_HOST);
    assign e_rvalid = reset && rd_pend_q &&
                      ((state_q == ST_ENGINE) || (state_q == ST_ENGINE_LOCK));
    assign h_rdata  = mem_q;
    assign e_rdata  = mem_q;

endmodule
